j_pulse_decode: RTL and testbench

Measures the DAC pulse stream in the audio DAC section and recovers the start phase and high width of each pulse. It watches the same 8-bit period counter that drives the pulse generator, sampled on rising edges of the slow `clk` strobe in the `sys_clk` domain. It emits one result per completed pulse, with a one-cycle valid strobe and an error flag. Loop-back checking of the DAC path and pulse-coded input capture both use it.

---
 rtl/j_pulse_decode_if.sv | 21 ++
 rtl/j_pulse_decode.sv | 106 ++++++++++
 tb/tb_j_pulse_decode.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/j_pulse_decode_if.sv
// Signal bundle between the DAC pulse stream and j_pulse_decode.
// The master drives the sampled clock/phase/pulse and the decoder (slave) returns each result.
interface j_pulse_decode_if;
    logic       clk;
    logic [7:0] a;
    logic       pulse;
    logic [6:0] pos;
    logic [7:0] width;
    logic       err;
    logic       valid;

    modport master (
        output clk, a, pulse,
        input  pos, width, err, valid
    );

    modport slave (
        input  clk, a, pulse,
        output pos, width, err, valid
    );
endinterface

// File: rtl/j_pulse_decode.sv
// Recovers start phase and high width of each DAC pulse, sampled on rising edges of the
// slow clk strobe in the sys_clk domain; one registered result strobe per completed pulse.
module j_pulse_decode #(
    parameter int unsigned WMAX = 255
) (
    input  logic            sys_clk,
    input  logic            reset,
    j_pulse_decode_if.slave bus
);
    localparam logic [7:0] WLIM = 8'(WMAX);

    typedef enum logic [1:0] {IDLE, HIGH, STUCK} state_t;

    state_t     state, state_nxt;
    logic       clk_q, pulse_q;
    logic [7:0] cnt, cnt_nxt;
    logic [6:0] pos_r, pos_r_nxt;
    logic       perr, perr_nxt;
    logic       pub, pub_err;
    logic [7:0] pub_width;
    logic [6:0] pos_q;
    logic [7:0] width_q;
    logic       err_q, valid_q;
    logic       tick, rise, fall;

    assign tick = bus.clk & ~clk_q;
    assign rise = tick &  bus.pulse & ~pulse_q;
    assign fall = tick & ~bus.pulse &  pulse_q;

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pos_r_nxt = pos_r;
        perr_nxt  = perr;
        pub       = 1'b0;
        pub_width = cnt;
        pub_err   = perr;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        cnt_nxt   = 8'd1;
                        pos_r_nxt = bus.a[6:0];
                        perr_nxt  = bus.a[7];
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        pub       = 1'b1;
                        state_nxt = IDLE;
                    end else if (bus.pulse) begin
                        if (cnt < WLIM) begin
                            cnt_nxt = cnt + 8'd1;
                        end else begin
                            // Saturated: report once, then wait out the pulse silently.
                            pub       = 1'b1;
                            pub_width = WLIM;
                            pub_err   = 1'b1;
                            state_nxt = STUCK;
                        end
                    end
                end
                STUCK: begin
                    if (fall) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_q   <= 1'b0;
            pulse_q <= 1'b1;  // a pulse already high at release must not count as a rise
            cnt     <= 8'd0;
            pos_r   <= 7'd0;
            perr    <= 1'b0;
            pos_q   <= 7'd0;
            width_q <= 8'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            clk_q   <= bus.clk;
            valid_q <= pub;
            if (tick) pulse_q <= bus.pulse;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pos_r   <= pos_r_nxt;
            perr    <= perr_nxt;
            if (pub) begin
                pos_q   <= pos_r;
                width_q <= pub_width;
                err_q   <= pub_err;
            end
        end
    end

    assign bus.pos   = pos_q;
    assign bus.width = width_q;
    assign bus.err   = err_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_j_pulse_decode.sv
// Randomized scoreboard bench for j_pulse_decode: a sample-level pulse model queues expected
// results with their due cycle; a monitor compares every valid strobe against the queue.
`timescale 1ns/1ps
module tb_j_pulse_decode;
    localparam int WMAX = 255;

    typedef struct {
        logic [6:0] pos;
        logic [7:0] width;
        logic       err;
        int         due;
    } exp_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    exp_t sb[$];

    // Reference model: counts high samples since the last rise.
    bit         m_prev = 1'b1;
    bit         m_meas = 1'b0;
    int         m_n    = 0;
    logic [7:0] m_a    = 8'd0;
    logic [7:0] a_ph   = 8'd0;

    j_pulse_decode_if bus ();

    j_pulse_decode #(.WMAX(WMAX)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [6:0] p, input logic [7:0] w, input logic e, input int due);
        exp_t x;
        x.pos = p; x.width = w; x.err = e; x.due = due;
        sb.push_back(x);
    endtask

    task automatic model_tick(input logic [7:0] av, input bit p, input int due);
        if (p && !m_prev) begin
            m_meas = 1'b1;
            m_n    = 1;
            m_a    = av;
        end else if (p && m_meas) begin
            m_n++;
            if (m_n > WMAX) begin
                push(m_a[6:0], 8'(WMAX), 1'b1, due);
                m_meas = 1'b0;
            end
        end else if (!p && m_meas) begin
            push(m_a[6:0], 8'(m_n), m_a[7], due);
            m_meas = 1'b0;
        end
        m_prev = p;
    endtask

    // One tick with phase av and pulse p, then random high/low dwell of the strobe.
    task automatic tick(input logic [7:0] av, input bit p);
        @(negedge sys_clk);
        bus.a     = av;
        bus.pulse = p;
        bus.clk   = 1'b1;
        model_tick(av, p, cyc + 1);
        repeat ($urandom_range(1, 3)) @(negedge sys_clk);
        bus.clk = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    endtask

    task automatic tick_ph(input bit p);
        tick(a_ph, p);
        a_ph = a_ph + 8'd1;
    endtask

    task automatic do_reset();
        repeat (2) @(negedge sys_clk);
        reset   = 1'b1;
        bus.clk = 1'b1;  // tick coincident with reset must be ignored
        m_prev  = 1'b1;
        m_meas  = 1'b0;
        @(negedge sys_clk);
        bus.clk = 1'b0;
        @(negedge sys_clk);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_pos",   32'(bus.pos),   32'd0);
        check("rst_width", 32'(bus.width), 32'd0);
        check("rst_err",   32'(bus.err),   32'd0);
        reset = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest queued result and its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (bus.valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pos",     32'(bus.pos),   32'(e.pos));
                    check("width",   32'(bus.width), 32'(e.width));
                    check("err",     32'(bus.err),   32'(e.err));
                    check("latency", 32'(cyc),       32'(e.due));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clk = 1'b0; bus.a = 8'd0; bus.pulse = 1'b0;
        do_reset();

        // Basic pulse at 0x10, five high samples.
        tick(8'h0F, 1'b0);
        a_ph = 8'h10;
        repeat (5) tick_ph(1'b1);
        tick_ph(1'b0);

        // Rise with the phase MSB set.
        a_ph = 8'h85;
        repeat (3) tick_ph(1'b1);
        tick_ph(1'b0);

        // Saturation, silent fall, then a short clean pulse.
        repeat (300) tick_ph(1'b1);
        tick_ph(1'b0);
        a_ph = 8'h02;
        repeat (2) tick_ph(1'b1);
        tick_ph(1'b0);

        // Back-to-back minimum pulses.
        tick_ph(1'b1); tick_ph(1'b0); tick_ph(1'b1); tick_ph(1'b0);

        // Reset mid-pulse with cnt=4; pulse still high after release.
        repeat (4) tick_ph(1'b1);
        do_reset();
        repeat (3) tick_ph(1'b1);
        tick_ph(1'b0);
        check("post_rst_pending", 32'(sb.size()), 32'd0);
        repeat (3) tick_ph(1'b1);
        tick_ph(1'b0);

        // Tick gating: strobe held high while pulse toggles.
        @(negedge sys_clk);
        bus.clk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            bus.pulse = ~bus.pulse;
        end
        bus.clk = 1'b0;
        check("gate_pending", 32'(sb.size()), 32'd0);
        check("gate_valid",   32'(bus.valid), 32'd0);

        // Random pulse trains with random phases.
        for (int i = 0; i < 300; i++) begin
            int hi, lo;
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 4);
            repeat (hi) tick(8'($urandom), 1'b1);
            repeat (lo) tick(8'($urandom), 1'b0);
        end

        repeat (5) @(negedge sys_clk);
        check("final_pending", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
